tmds_align_ctrl: RTL and testbench
==================================

Name: tmds_align_ctrl

Overview:
Per-channel alignment controller for the HDMI passthrough receive path, in the clk_pixel domain.
- Takes the raw 10-bit deserialized word of one TMDS channel.
- Sequences that channel's input DELAYF tap (LOADN/MOVE/DIRECTION) and a 0..9 bit-slip until TMDS control tokens are seen reliably.
- Emits the aligned word and a lock flag; monitors lock continuously and re-sweeps on loss.
- Three instances, one per channel (r/g/b).

Parameters:
WINDOW, 2048, observation window length in clk_pixel cycles (spans more than one 720p line)
MIN_TOKENS, 64, control-token count per window required to pass
SETTLE, 16, cycles waited after any tap or slip change before counting
MAX_TAPS, 128, number of DELAYF taps swept (7-bit tap)
LOSS_WINDOWS, 2, consecutive failing windows in LOCKED before relock

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
word_in  in  10  raw deserialized word; bit 0 = first received bit
aligned_word  out  10  slip-corrected word
locked  out  1  channel aligned
slip  out  4  current bit-slip, 0..9
tap  out  7  current delay tap count since last load
delay_loadn  out  1  to DELAYF LOADN; active-low one-cycle pulse
delay_move  out  1  to DELAYF MOVE; one-cycle pulse
delay_direction  out  1  to DELAYF DIRECTION; tied 0 (increase delay)
relock_count  out  8  saturating count of lock losses

Behaviour:
Reset values:
- aligned_word=0, locked=0, slip=0, tap=0, delay_loadn=1, delay_move=0, relock_count=0.
- State is LOAD on the first cycle after rst deasserts.

Slip datapath:
- Each cycle: word_d <= word_in; aligned_word <= {word_in, word_d}[slip +: 10].
- Latency is 1 cycle.
- A slip change affects the next aligned_word.

Token detect:
- hit = aligned_word is one of 0x354, 0x0AB, 0x154, 0x2AB.
- token_cnt saturates at MIN_TOKENS.

FSM:
- LOAD (1 cycle):
  - Assert delay_loadn=0.
  - Set tap=0, slip=0.
  - Go to SETTLE.
- SETTLE:
  - Wait SETTLE cycles.
  - Clear token_cnt and window counter.
  - Go to COUNT.
- COUNT:
  - Run exactly WINDOW cycles, incrementing token_cnt on hit, including a hit on the last cycle.
  - Then go to DECIDE.
- DECIDE (1 cycle), first matching case wins:
  - token_cnt >= MIN_TOKENS: set locked=1, clear loss counter, go to LOCKED.
  - slip < 9: slip++, go to SETTLE.
  - tap < MAX_TAPS-1: slip=0, tap++, assert delay_move=1 for this cycle, go to SETTLE.
  - Otherwise (full sweep failed): go to LOAD.
- LOCKED:
  - Repeats WINDOW-cycle windows with no settle between them; slip and tap are frozen.
  - Window passes: loss counter = 0.
  - Window fails: loss counter++.
  - Loss counter reaches LOSS_WINDOWS: locked=0, relock_count++ (saturating at 255), go to LOAD.
  - locked drops on the same edge that enters LOAD.
- Timing per attempt:
  - Each unlocked attempt costs SETTLE + WINDOW + 1 cycles.
  - Defaults: lock at slip s, tap t is reached 1 + (10t + s + 1) × 2065 cycles after rst deassert.

Boundaries and edge cases:
- rst mid-operation: every output returns to its reset value on the next edge, including a pulse that is in progress.
- Pulse exclusivity: delay_loadn and delay_move are never active in the same cycle.
- Pulse width: each pulse is exactly 1 cycle wide.
- Tap overflow: tap never exceeds MAX_TAPS-1.

Decomposition:
- Shared package tmds_pkg:
  - The four control-token constants.
  - FSM state enum (LOAD, SETTLE, COUNT, DECIDE, LOCKED).
  - $clog2-derived counter widths.
- One sub-module, tmds_word_slip: word_d register plus the 20→10 slip mux, with registered output.

Test Plan:
1. Stream repeating 0x354 pre-rotated so concat offset 3 matches → locked=1 with slip=3, tap=0, at cycle 1 + 4×2065 = 8261 after reset; aligned_word=0x354.
2. Random data with no tokens:
   - After 10 attempts: one delay_move pulse, tap=1, slip=0.
   - After 1280 attempts: one delay_loadn pulse, tap=0.
3. Locked, then token-free data → locked falls at end of 2nd failing window; relock_count=1; delay_loadn pulses next.
4. Locked, one failing window then tokens resume → locked stays 1; relock_count=0.
5. Window containing exactly 63 hits fails (slip advances); exactly 64 hits, the last one on the final COUNT cycle, locks.
6. rst asserted during COUNT with slip=5 → next cycle all outputs at reset values; after release, delay_loadn=0 for exactly 1 cycle.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel alignment controller: control tokens,
// FSM states, fixed port widths and a counter-width helper.
package tmds_pkg;

    localparam int WORD_W   = 10;
    localparam int SLIP_W   = 4;
    localparam int TAP_W    = 7;
    localparam int RELOCK_W = 8;

    localparam logic [WORD_W-1:0] TOKEN_0 = 10'h354;
    localparam logic [WORD_W-1:0] TOKEN_1 = 10'h0AB;
    localparam logic [WORD_W-1:0] TOKEN_2 = 10'h154;
    localparam logic [WORD_W-1:0] TOKEN_3 = 10'h2AB;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_COUNT,
        ST_DECIDE,
        ST_LOCKED
    } state_t;

    // Width needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic is_token(input logic [WORD_W-1:0] w);
        return (w == TOKEN_0) || (w == TOKEN_1) || (w == TOKEN_2) || (w == TOKEN_3);
    endfunction

endpackage

// File: rtl/tmds_align_ctrl_if.sv
// Per-channel bundle between the deserializer/DELAYF side and the alignment
// controller; master is the controller, slave is whoever feeds and observes it.
interface tmds_align_ctrl_if;
    import tmds_pkg::*;

    logic [WORD_W-1:0]   word_in;
    logic [WORD_W-1:0]   aligned_word;
    logic                locked;
    logic [SLIP_W-1:0]   slip;
    logic [TAP_W-1:0]    tap;
    logic                delay_loadn;
    logic                delay_move;
    logic                delay_direction;
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        input  word_in,
        output aligned_word, locked, slip, tap,
               delay_loadn, delay_move, delay_direction, relock_count
    );

    modport slave (
        output word_in,
        input  aligned_word, locked, slip, tap,
               delay_loadn, delay_move, delay_direction, relock_count
    );

endinterface

// File: rtl/tmds_word_slip.sv
// Bit-slip datapath: previous word register plus a 20-to-10 window select,
// registered output (one cycle from word_in to aligned_word).
module tmds_word_slip
    import tmds_pkg::*;
(
    input  logic              clk_pixel,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic [SLIP_W-1:0] slip,
    output logic [WORD_W-1:0] aligned_word
);

    logic [WORD_W-1:0]   word_d_reg;
    logic [WORD_W-1:0]   aligned_reg;
    logic [2*WORD_W-1:0] concat;
    logic [WORD_W-1:0]   shifted [0:WORD_W-1];

    // Bit 0 is the first received bit, so the older word sits in the low half.
    assign concat = {word_in, word_d_reg};

    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_shift
            assign shifted[gi] = concat[gi +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            word_d_reg  <= '0;
            aligned_reg <= '0;
        end else begin
            word_d_reg  <= word_in;
            aligned_reg <= shifted[slip];
        end
    end

    assign aligned_word = aligned_reg;

endmodule

// File: rtl/tmds_align_ctrl.sv
// TMDS channel alignment controller: sweeps DELAYF taps and bit-slips until
// control tokens are seen often enough, then watches lock and re-sweeps on loss.
module tmds_align_ctrl
    import tmds_pkg::*;
#(
    parameter int WINDOW       = 2048,
    parameter int MIN_TOKENS   = 64,
    parameter int SETTLE       = 16,
    parameter int MAX_TAPS     = 128,
    parameter int LOSS_WINDOWS = 2
) (
    input  logic               clk_pixel,
    input  logic               rst,
    tmds_align_ctrl_if.master  bus
);

    localparam int WIN_W  = cnt_width(WINDOW - 1);
    localparam int TOK_W  = cnt_width(MIN_TOKENS);
    localparam int SET_W  = cnt_width(SETTLE - 1);
    localparam int LOSS_W = cnt_width(LOSS_WINDOWS);

    state_t              state_reg;
    logic [SLIP_W-1:0]   slip_reg;
    logic [TAP_W-1:0]    tap_reg;
    logic                loadn_reg;
    logic                move_reg;
    logic                locked_reg;
    logic [RELOCK_W-1:0] relock_reg;
    logic [WIN_W-1:0]    win_cnt_reg;
    logic [TOK_W-1:0]    tok_cnt_reg;
    logic [SET_W-1:0]    set_cnt_reg;
    logic [LOSS_W-1:0]   loss_cnt_reg;

    logic [WORD_W-1:0]   aligned_word;
    logic                hit;
    logic [TOK_W-1:0]    tok_cnt_next;
    logic                win_last;
    logic                window_pass;

    tmds_word_slip u_slip (
        .clk_pixel    (clk_pixel),
        .rst          (rst),
        .word_in      (bus.word_in),
        .slip         (slip_reg),
        .aligned_word (aligned_word)
    );

    assign hit          = is_token(aligned_word);
    assign tok_cnt_next = (hit && (tok_cnt_reg < TOK_W'(MIN_TOKENS)))
                          ? tok_cnt_reg + TOK_W'(1) : tok_cnt_reg;
    assign win_last     = (win_cnt_reg == WIN_W'(WINDOW - 1));
    // The hit of the final window cycle must count toward the verdict.
    assign window_pass  = (tok_cnt_next >= TOK_W'(MIN_TOKENS));

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_reg    <= ST_LOAD;
            slip_reg     <= '0;
            tap_reg      <= '0;
            loadn_reg    <= 1'b1;
            move_reg     <= 1'b0;
            locked_reg   <= 1'b0;
            relock_reg   <= '0;
            win_cnt_reg  <= '0;
            tok_cnt_reg  <= '0;
            set_cnt_reg  <= '0;
            loss_cnt_reg <= '0;
        end else begin
            loadn_reg <= 1'b1;
            move_reg  <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    loadn_reg   <= 1'b0;
                    tap_reg     <= '0;
                    slip_reg    <= '0;
                    set_cnt_reg <= '0;
                    state_reg   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (set_cnt_reg == SET_W'(SETTLE - 1)) begin
                        win_cnt_reg <= '0;
                        tok_cnt_reg <= '0;
                        state_reg   <= ST_COUNT;
                    end else begin
                        set_cnt_reg <= set_cnt_reg + SET_W'(1);
                    end
                end
                ST_COUNT: begin
                    tok_cnt_reg <= tok_cnt_next;
                    if (win_last) begin
                        state_reg <= ST_DECIDE;
                    end else begin
                        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                    end
                end
                ST_DECIDE: begin
                    set_cnt_reg <= '0;
                    if (tok_cnt_reg >= TOK_W'(MIN_TOKENS)) begin
                        locked_reg   <= 1'b1;
                        loss_cnt_reg <= '0;
                        win_cnt_reg  <= '0;
                        tok_cnt_reg  <= '0;
                        state_reg    <= ST_LOCKED;
                    end else if (slip_reg < SLIP_W'(9)) begin
                        slip_reg  <= slip_reg + SLIP_W'(1);
                        state_reg <= ST_SETTLE;
                    end else if (tap_reg < TAP_W'(MAX_TAPS - 1)) begin
                        slip_reg  <= '0;
                        tap_reg   <= tap_reg + TAP_W'(1);
                        move_reg  <= 1'b1;
                        state_reg <= ST_SETTLE;
                    end else begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOCKED: begin
                    if (win_last) begin
                        win_cnt_reg <= '0;
                        tok_cnt_reg <= '0;
                        if (window_pass) begin
                            loss_cnt_reg <= '0;
                        end else if (loss_cnt_reg == LOSS_W'(LOSS_WINDOWS - 1)) begin
                            locked_reg   <= 1'b0;
                            loss_cnt_reg <= '0;
                            if (relock_reg != {RELOCK_W{1'b1}}) begin
                                relock_reg <= relock_reg + RELOCK_W'(1);
                            end
                            state_reg <= ST_LOAD;
                        end else begin
                            loss_cnt_reg <= loss_cnt_reg + LOSS_W'(1);
                        end
                    end else begin
                        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                        tok_cnt_reg <= tok_cnt_next;
                    end
                end
                default: state_reg <= ST_LOAD;
            endcase
        end
    end

    assign bus.aligned_word    = aligned_word;
    assign bus.locked          = locked_reg;
    assign bus.slip            = slip_reg;
    assign bus.tap             = tap_reg;
    assign bus.delay_loadn     = loadn_reg;
    assign bus.delay_move      = move_reg;
    assign bus.delay_direction = 1'b0;
    assign bus.relock_count    = relock_reg;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Directed bench for tmds_align_ctrl with shortened windows so a full tap
// sweep fits in a short run; each attempt is SETTLE+WINDOW+1 = 37 cycles.
module tb_tmds_align_ctrl;
    import tmds_pkg::*;

    localparam int WINDOW       = 32;
    localparam int MIN_TOKENS   = 4;
    localparam int SETTLE       = 4;
    localparam int MAX_TAPS     = 4;
    localparam int LOSS_WINDOWS = 2;

    localparam int M_ZERO  = 0;
    localparam int M_TOKEN = 1;
    localparam int M_NOISE = 2;
    localparam int M_SCHED = 3;

    // 0x354 rotated left by 3, so slip 3 recovers the token
    localparam logic [9:0] TOK_WORD = 10'h2A6;

    logic clk_pixel = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   mode = M_ZERO;
    int   n_cmp = 0;
    int   n_bad = 0;

    tmds_align_ctrl_if bus();

    tmds_align_ctrl #(
        .WINDOW       (WINDOW),
        .MIN_TOKENS   (MIN_TOKENS),
        .SETTLE       (SETTLE),
        .MAX_TAPS     (MAX_TAPS),
        .LOSS_WINDOWS (LOSS_WINDOWS)
    ) dut (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Cycle index since reset release; cycle 0 is the LOAD cycle.
    always @(posedge clk_pixel) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s = 0x%0h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    // Test-5 stimulus: three slip-0 tokens in attempt 1, four slip-1 tokens
    // in attempt 2 with the last one landing on the final COUNT cycle (73).
    function automatic logic [9:0] sched_word(input int n);
        case (n)
            8, 18, 34:      return 10'h354;
            43, 53, 63, 71: return 10'h2A8;
            44, 54, 64, 72: return 10'h001;
            default:        return 10'h000;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk_pixel);
        case (mode)
            M_TOKEN: bus.word_in = TOK_WORD;
            M_NOISE: bus.word_in = ($urandom_range(0, 1) != 0) ? 10'h3FF : 10'h000;
            M_SCHED: bus.word_in = sched_word(cyc);
            default: bus.word_in = 10'h000;
        endcase
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input int m);
        @(negedge clk_pixel);
        rst  = 1'b1;
        mode = m;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_aligned"}, 32'(bus.aligned_word), 0);
        check({pfx, "_locked"},  32'(bus.locked), 0);
        check({pfx, "_slip"},    32'(bus.slip), 0);
        check({pfx, "_tap"},     32'(bus.tap), 0);
        check({pfx, "_loadn"},   32'(bus.delay_loadn), 1);
        check({pfx, "_move"},    32'(bus.delay_move), 0);
        check({pfx, "_relock"},  32'(bus.relock_count), 0);
    endtask

    initial begin
        int moves;
        int loads;
        int both;
        int max_tap;

        bus.word_in = 10'h000;

        // Reset values
        repeat (3) tick();
        check_reset_outputs("rst");
        check("rst_direction", 32'(bus.delay_direction), 0);

        // Token-free sweep: move after 10 attempts, reload after 40
        do_reset(M_NOISE);
        wait_cyc(370);
        check("sweep_move_before", 32'(bus.delay_move), 0);
        check("sweep_slip_before", 32'(bus.slip), 9);
        tick();
        check("sweep_move_pulse", 32'(bus.delay_move), 1);
        check("sweep_tap_after_move", 32'(bus.tap), 1);
        check("sweep_slip_after_move", 32'(bus.slip), 0);
        check("sweep_loadn_excl", 32'(bus.delay_loadn), 1);
        tick();
        check("sweep_move_width", 32'(bus.delay_move), 0);
        moves = 0; loads = 0; both = 0; max_tap = 0;
        while (cyc < 1482) begin
            tick();
            if (bus.delay_move === 1'b1) moves++;
            if (bus.delay_loadn === 1'b0) loads++;
            if (bus.delay_move === 1'b1 && bus.delay_loadn === 1'b0) both++;
            if (int'(bus.tap) > max_tap) max_tap = int'(bus.tap);
        end
        check("sweep_loadn_at_end", 32'(bus.delay_loadn), 0);
        check("sweep_tap_reload", 32'(bus.tap), 0);
        check("sweep_slip_reload", 32'(bus.slip), 0);
        check("sweep_move_count", 32'(moves), 2);
        check("sweep_load_count", 32'(loads), 1);
        check("sweep_pulse_overlap", 32'(both), 0);
        check("sweep_max_tap", 32'(max_tap), MAX_TAPS - 1);
        tick();
        check("sweep_loadn_width", 32'(bus.delay_loadn), 1);

        // Reset during COUNT at slip 5
        do_reset(M_NOISE);
        wait_cyc(200);
        check("midrst_slip", 32'(bus.slip), 5);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        check("midrst_loadn_c0", 32'(bus.delay_loadn), 1);
        tick();
        check("midrst_loadn_c1", 32'(bus.delay_loadn), 0);
        tick();
        check("midrst_loadn_c2", 32'(bus.delay_loadn), 1);

        // Lock at slip 3, then lose tokens for two windows
        do_reset(M_TOKEN);
        while (bus.locked !== 1'b1 && cyc < 400) tick();
        check("lock_cycle", 32'(cyc), 1 + 4 * (SETTLE + WINDOW + 1));
        check("lock_slip", 32'(bus.slip), 3);
        check("lock_tap", 32'(bus.tap), 0);
        check("lock_aligned", 32'(bus.aligned_word), 32'(TOKEN_0));
        mode = M_ZERO;
        while (bus.locked === 1'b1 && cyc < 400) tick();
        check("loss_cycle", 32'(cyc), 213);
        check("loss_relock_count", 32'(bus.relock_count), 1);
        check("loss_loadn_same_edge", 32'(bus.delay_loadn), 1);
        tick();
        check("loss_loadn_next", 32'(bus.delay_loadn), 0);
        check("loss_slip_cleared", 32'(bus.slip), 0);

        // Single failing windows separated by passing ones keep lock
        do_reset(M_TOKEN);
        wait_cyc(149);
        check("hold_locked_start", 32'(bus.locked), 1);
        mode = M_ZERO;
        wait_cyc(180);
        mode = M_TOKEN;
        wait_cyc(243);
        mode = M_ZERO;
        wait_cyc(276);
        mode = M_TOKEN;
        wait_cyc(277);
        check("hold_locked_after_w4", 32'(bus.locked), 1);
        wait_cyc(310);
        check("hold_locked_end", 32'(bus.locked), 1);
        check("hold_relock_count", 32'(bus.relock_count), 0);

        // Threshold: 3 hits fail, 4 hits (last on final COUNT cycle) lock
        do_reset(M_SCHED);
        wait_cyc(37);
        check("thr_unlocked_decide1", 32'(bus.locked), 0);
        wait_cyc(38);
        check("thr_slip_advanced", 32'(bus.slip), 1);
        check("thr_unlocked_after3", 32'(bus.locked), 0);
        wait_cyc(74);
        check("thr_unlocked_decide2", 32'(bus.locked), 0);
        wait_cyc(75);
        check("thr_locked_at4", 32'(bus.locked), 1);
        check("thr_lock_slip", 32'(bus.slip), 1);
        check("thr_lock_tap", 32'(bus.tap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
